// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the RISC15 pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    // IR value the datapath loads into a flushed pipeline register
    localparam logic [15:0] NOP_IR = 16'hE000;

    typedef enum logic {
        RUN  = 1'b0,
        LMSM = 1'b1
    } state_t;

    function automatic logic is_lmsm_op(input logic [3:0] opcode);
        return (opcode == OP_LM) || (opcode == OP_SM);
    endfunction

endpackage

// File: rtl/lmsm_priority_encoder.sv
// Finds the lowest set bit of an LM/SM register mask and flags a single-bit mask.
module lmsm_priority_encoder (
    input  logic [7:0] mask,
    output logic [2:0] index,
    output logic       valid,
    output logic       single
);

    always_comb begin
        index = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) index = 3'(i);
        end
    end

    assign valid  = |mask;
    assign single = valid && ((mask & (mask - 8'd1)) == 8'd0);

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the six-stage RISC15 pipeline, including LM/SM splitting.
// Optional PIPE_CTRL_PERF_EN adds saturating stall_cycles / flush_events counters.
//
// state | meaning
// RUN   | normal flow; branch flush, load-use stall, LM/SM entry
// LMSM  | issuing remaining LM/SM transfers, front end held
module pipeline_controller
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] rr_ir,
    input  logic [2:0]  rr_src1,
    input  logic [2:0]  rr_src2,
    input  logic [1:0]  rr_src_used,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_dest,
    input  logic        ex_branch_taken,
    output logic        pc_write_n,
    output logic        p1_write_n,
    output logic        p2_write_n,
    output logic        p3_write_n,
    output logic        p1_flush,
    output logic        p2_flush,
    output logic        p3_flush,
    output logic        lmsm_valid,
    output logic [2:0]  lmsm_reg,
    output logic [2:0]  lmsm_offset,
    output logic        lmsm_last,
    output logic        busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
`endif
);

    state_t     state, next_state;
    logic [7:0] mask_q, next_mask;
    logic [2:0] offset_q, next_offset;
    logic [2:0] ent_idx, rem_idx;
    logic       ent_valid, ent_single, rem_valid, rem_single;
    logic       load_use;
    logic       unused_ir;

    assign unused_ir = ^rr_ir[11:8];

    lmsm_priority_encoder u_ent_enc (
        .mask   (rr_ir[7:0]),
        .index  (ent_idx),
        .valid  (ent_valid),
        .single (ent_single)
    );

    lmsm_priority_encoder u_rem_enc (
        .mask   (mask_q),
        .index  (rem_idx),
        .valid  (rem_valid),
        .single (rem_single)
    );

    assign load_use = ex_is_load &&
                      ((rr_src_used[0] && (ex_dest == rr_src1)) ||
                       (rr_src_used[1] && (ex_dest == rr_src2)));

    // Outputs are forced to their idle values while reset is held.
    always_comb begin
        pc_write_n  = 1'b0;
        p1_write_n  = 1'b0;
        p2_write_n  = 1'b0;
        p3_write_n  = 1'b0;
        p1_flush    = 1'b0;
        p2_flush    = 1'b0;
        p3_flush    = 1'b0;
        lmsm_valid  = 1'b0;
        lmsm_reg    = 3'd0;
        lmsm_offset = 3'd0;
        lmsm_last   = 1'b0;
        busy        = 1'b0;
        next_state  = state;
        next_mask   = mask_q;
        next_offset = offset_q;
        if (reset) begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        p1_flush = 1'b1;
                        p2_flush = 1'b1;
                        p3_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write_n = 1'b1;
                        p1_write_n = 1'b1;
                        p2_write_n = 1'b1;
                        p3_flush   = 1'b1;
                    end else if (is_lmsm_op(rr_ir[15:12]) && ent_valid) begin
                        lmsm_valid = 1'b1;
                        lmsm_reg   = ent_idx;
                        if (ent_single) begin
                            lmsm_last = 1'b1;
                        end else begin
                            pc_write_n  = 1'b1;
                            p1_write_n  = 1'b1;
                            p2_write_n  = 1'b1;
                            next_mask   = rr_ir[7:0] & ~(8'd1 << ent_idx);
                            next_offset = 3'd1;
                            next_state  = LMSM;
                        end
                    end
                end
                LMSM: begin
                    busy = 1'b1;
                    if (ex_branch_taken) begin
                        p1_flush    = 1'b1;
                        p2_flush    = 1'b1;
                        p3_flush    = 1'b1;
                        next_mask   = 8'd0;
                        next_offset = 3'd0;
                        next_state  = RUN;
                    end else begin
                        lmsm_valid  = rem_valid;
                        lmsm_reg    = rem_idx;
                        lmsm_offset = offset_q;
                        pc_write_n  = 1'b1;
                        p1_write_n  = 1'b1;
                        next_mask   = mask_q & ~(8'd1 << rem_idx);
                        next_offset = offset_q + 3'd1;
                        if (rem_single || !rem_valid) begin
                            lmsm_last   = 1'b1;
                            next_offset = 3'd0;
                            next_state  = RUN;
                        end else begin
                            p2_write_n = 1'b1;
                        end
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            mask_q   <= 8'd0;
            offset_q <= 3'd0;
        end else begin
            state    <= next_state;
            mask_q   <= next_mask;
            offset_q <= next_offset;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= 16'd0;
            flush_events <= 16'd0;
        end else begin
            if (pc_write_n && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (ex_branch_taken && (flush_events != 16'hFFFF))
                flush_events <= flush_events + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: a list-based reference model predicts each
// cycle's controls; a separate monitor compares them mid-cycle.
module tb_pipeline_controller;

    typedef struct packed {
        logic       pc, p1, p2, p3;
        logic       f1, f2, f3;
        logic       valid;
        logic [2:0] rg;
        logic [2:0] off;
        logic       last;
        logic       busy;
    } exp_t;

    typedef struct packed {
        exp_t e;
        logic br;
        logic rst;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] rr_ir = 16'h0;
    logic [2:0]  rr_src1 = 3'd0, rr_src2 = 3'd0, ex_dest = 3'd0;
    logic [1:0]  rr_src_used = 2'b00;
    logic        ex_is_load = 1'b0, ex_branch_taken = 1'b0;
    logic        pc_write_n, p1_write_n, p2_write_n, p3_write_n;
    logic        p1_flush, p2_flush, p3_flush;
    logic        lmsm_valid, lmsm_last, busy;
    logic [2:0]  lmsm_reg, lmsm_offset;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cycles, flush_events;
    logic [15:0] m_stall = 16'd0, m_flush = 16'd0;
`endif

    int    total = 0;
    int    bad = 0;
    item_t sbq[$];
    int    pending[$];
    int    off_m = 0;
    exp_t  act;

    assign act = {pc_write_n, p1_write_n, p2_write_n, p3_write_n, p1_flush, p2_flush,
                  p3_flush, lmsm_valid, lmsm_reg, lmsm_offset, lmsm_last, busy};

    always #5 clk = ~clk;

    pipeline_controller dut (
        .clk             (clk),
        .reset           (reset),
        .rr_ir           (rr_ir),
        .rr_src1         (rr_src1),
        .rr_src2         (rr_src2),
        .rr_src_used     (rr_src_used),
        .ex_is_load      (ex_is_load),
        .ex_dest         (ex_dest),
        .ex_branch_taken (ex_branch_taken),
        .pc_write_n      (pc_write_n),
        .p1_write_n      (p1_write_n),
        .p2_write_n      (p2_write_n),
        .p3_write_n      (p3_write_n),
        .p1_flush        (p1_flush),
        .p2_flush        (p2_flush),
        .p3_flush        (p3_flush),
        .lmsm_valid      (lmsm_valid),
        .lmsm_reg        (lmsm_reg),
        .lmsm_offset     (lmsm_offset),
        .lmsm_last       (lmsm_last),
        .busy            (busy)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
`endif
    );

    // Drive one cycle of inputs and push the model's prediction for that cycle.
    task automatic step(input logic rst, input logic [15:0] ir, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [1:0] used, input logic ld,
                        input logic [2:0] dest, input logic br);
        exp_t  e;
        item_t it;
        logic  lu;
        int    regs[$];
        @(posedge clk);
        #1;
        reset = rst; rr_ir = ir; rr_src1 = s1; rr_src2 = s2; rr_src_used = used;
        ex_is_load = ld; ex_dest = dest; ex_branch_taken = br;
        e = '0;
        lu = ld && ((used[0] && dest == s1) || (used[1] && dest == s2));
        if (!rst) begin
            pending.delete();
            off_m = 0;
        end else if (pending.size() > 0) begin
            e.busy = 1'b1;
            if (br) begin
                e.f1 = 1'b1; e.f2 = 1'b1; e.f3 = 1'b1;
                pending.delete();
                off_m = 0;
            end else begin
                e.valid = 1'b1;
                e.rg    = 3'(pending.pop_front());
                e.off   = 3'(off_m);
                off_m++;
                e.pc = 1'b1; e.p1 = 1'b1;
                if (pending.size() == 0) begin
                    e.last = 1'b1;
                    off_m  = 0;
                end else begin
                    e.p2 = 1'b1;
                end
            end
        end else if (br) begin
            e.f1 = 1'b1; e.f2 = 1'b1; e.f3 = 1'b1;
        end else if (lu) begin
            e.pc = 1'b1; e.p1 = 1'b1; e.p2 = 1'b1; e.f3 = 1'b1;
        end else if ((ir[15:12] == 4'd6 || ir[15:12] == 4'd7) && ir[7:0] != 8'd0) begin
            for (int i = 0; i < 8; i++) if (ir[i]) regs.push_back(i);
            e.valid = 1'b1;
            e.rg    = 3'(regs[0]);
            if (regs.size() == 1) begin
                e.last = 1'b1;
            end else begin
                e.pc = 1'b1; e.p1 = 1'b1; e.p2 = 1'b1;
                void'(regs.pop_front());
                pending = regs;
                off_m = 1;
            end
        end
        it.e = e; it.br = br; it.rst = rst;
        sbq.push_back(it);
    endtask

    task automatic idle();
        step(1'b1, 16'h1000, 3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                it = sbq.pop_front();
                total++;
                if (act !== it.e)
                    begin bad++; $display("FAIL outputs t=%0t: got=%h want=%h", $time, act, it.e); end
`ifdef PIPE_CTRL_PERF_EN
                if (!it.rst) begin m_stall = 16'd0; m_flush = 16'd0; end
                total++;
                if (stall_cycles !== m_stall || flush_events !== m_flush)
                    begin bad++; $display("FAIL perf t=%0t: got=%h/%h want=%h/%h", $time,
                                          stall_cycles, flush_events, m_stall, m_flush); end
                if (it.rst) begin
                    if (it.e.pc && m_stall != 16'hFFFF) m_stall++;
                    if (it.br && m_flush != 16'hFFFF) m_flush++;
                end
`endif
            end
        end
    end

    initial begin : stim
        logic [3:0] ops [4];
        logic [7:0] m;
        ops[0] = 4'd1; ops[1] = 4'd4; ops[2] = 4'd6; ops[3] = 4'd7;
        step(1'b0, 16'h60FF, 3'd3, 3'd3, 2'b11, 1'b1, 3'd3, 1'b1);
        step(1'b0, 16'h0000, 3'd0, 3'd0, 2'b00, 1'b0, 3'd0, 1'b0);
        idle();
        step(1'b1, 16'h1000, 3'd3, 3'd5, 2'b01, 1'b1, 3'd3, 1'b0);
        idle();
        step(1'b1, 16'h1000, 3'd3, 3'd5, 2'b00, 1'b1, 3'd3, 1'b0);
        step(1'b1, 16'h1000, 3'd1, 3'd5, 2'b10, 1'b1, 3'd5, 1'b0);
        step(1'b1, 16'h1000, 3'd5, 3'd1, 2'b01, 1'b1, 3'd1, 1'b0);
        repeat (3) step(1'b1, 16'h6025, 3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b0);
        idle();
        step(1'b1, 16'h7080, 3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b0);
        step(1'b1, 16'h6000, 3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b0);
        repeat (2) step(1'b1, 16'h60FF, 3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b0);
        step(1'b1, 16'h60FF, 3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b1);
        idle();
        step(1'b1, 16'h6025, 3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b1);
        step(1'b1, 16'h6025, 3'd4, 3'd2, 2'b01, 1'b1, 3'd4, 1'b0);
        repeat (2) step(1'b1, 16'h60F0, 3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b0);
        step(1'b0, 16'h60F0, 3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b0);
        idle();
        idle();
        for (int n = 0; n < 3000; n++) begin
            m = 8'($urandom);
            if ($urandom_range(0, 3) == 0) m = 8'd1 << $urandom_range(0, 7);
            step(($urandom_range(0, 199) != 0),
                 {ops[$urandom_range(0, 3)], 4'($urandom), m},
                 3'($urandom), 3'($urandom), 2'($urandom),
                 ($urandom_range(0, 2) == 0), 3'($urandom),
                 ($urandom_range(0, 11) == 0));
        end
`ifdef PIPE_CTRL_PERF_EN
        step(1'b0, 16'h1000, 3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b0);
        repeat (70000) step(1'b1, 16'h1000, 3'd1, 3'd2, 2'b01, 1'b1, 3'd1, 1'b0);
        repeat (2) step(1'b1, 16'h1000, 3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b1);
        idle();
`endif
        repeat (3) @(posedge clk);
        total++;
        if (sbq.size() != 0)
            begin bad++; $display("FAIL drain: got=%0d queued want=0", sbq.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the six-stage RISC15 pipeline (IF, ID, RR, EX, MEM, WB). It drives the load-enable and NOP-insert controls of the PC and the first three pipeline registers. It resolves load-use hazards and taken-branch flushes, and breaks LM/SM instructions into one register transfer per cycle. It sits beside the datapath and owns no datapath state other than the LM/SM mask.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- rr_ir  in  16  instruction currently in the RR stage; [15:12] opcode, [7:0] LM/SM register mask
- rr_src1, rr_src2  in  3  RR source register addresses
- rr_src_used  in  2  bit0/bit1 mark rr_src1/rr_src2 as actually read
- ex_is_load  in  1  EX-stage instruction is LW or an LM transfer
- ex_dest  in  3  EX-stage destination register
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- pc_write_n, p1_write_n, p2_write_n, p3_write_n  out  1  register load enable, 0 = load, 1 = hold
- p1_flush, p2_flush, p3_flush  out  1  1 = register loads NOP IR and cleared controls
- lmsm_valid  out  1  RR→EX micro-op this cycle is an LM/SM transfer
- lmsm_reg  out  3  register index of that transfer
- lmsm_offset  out  3  transfer ordinal (memory address = base + offset)
- lmsm_last  out  1  final transfer of the instruction
- busy  out  1  state is LMSM

## Operation
- States: RUN, LMSM. Reset value is RUN, mask register 0, offset counter 0.
- Default in RUN: all write_n = 0, all flush = 0, lmsm_valid = 0.
- Priority, highest first: branch flush, load-use stall (RUN only), LM/SM sequencing.
- Branch: ex_branch_taken = 1 gives p1/p2/p3_flush = 1 and pc_write_n = 0. In LMSM it aborts to RUN and clears the mask and offset.
- Load-use: ex_is_load and ex_dest equal to a used rr_src gives pc/p1/p2_write_n = 1 and p3_flush = 1, inserting one bubble.
- LM/SM entry (RUN): rr_ir opcode 0110/0111 with mask ≠ 0.
  - lmsm_valid = 1, lmsm_reg = lowest set bit, lmsm_offset = 0.
  - If more than one bit is set: pc/p1/p2_write_n = 1, the remaining mask is latched, and the next state is LMSM.
  - If exactly one bit is set: lmsm_last = 1, no stall, remain in RUN.
- LM/SM with mask = 0: no transfer; it passes as NOP.
- LMSM state, each cycle:
  - Issue the lowest remaining bit and clear it from the mask; offset increments by 1 (3-bit, at most 7 is reached).
  - pc/p1_write_n = 1.
  - p2_write_n = 1 until the cycle that issues the last bit. On that cycle p2_write_n = 0, lmsm_last = 1, and the next state is RUN.
- Load-use is not checked in LMSM; the base register is checked before entry.

## Timing
- All hazard outputs are combinational from the inputs and state in the same cycle.
- Outputs during reset: write_n = 0, flush = 0, lmsm_* = 0, busy = 0.
- Load-use penalty: exactly 1 cycle.
- Branch penalty: 3 squashed instructions.
- LM/SM with k set bits: k consecutive lmsm_valid cycles, k−1 front-end stall cycles, busy high for k−1 cycles.
- A branch and an LM/SM entry in the same cycle: the branch wins and no transfer issues.
- Reset asserted mid-LMSM: immediately returns to RUN with the mask cleared.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs stall_cycles[15:0] and flush_events[15:0].
  - Both counters saturate at 0xFFFF and reset to 0.
  - stall_cycles increments on any cycle with pc_write_n = 1.
  - flush_events increments once per taken branch.
- PIPE_CTRL_PERF_EN undefined: these ports and counters are absent and behaviour is otherwise identical.

## Structure
- Package pipe_ctrl_pkg:
  - opcode constants (OP_LW 0100, OP_LM 0110, OP_SM 0111)
  - state enum {RUN, LMSM}
  - NOP IR constant
- Sub-module lmsm_priority_encoder: 8-bit mask in; lowest index (3), valid, and single-bit flag out. It is used for both the entry mask and the latched mask.

## Test plan
- LW r3 in EX, RR reads r3 as src1 (rr_src_used = 01) → one cycle with pc/p1/p2_write_n = 1 and p3_flush = 1, then normal flow.
- Same as above but rr_src_used = 00 → no stall.
- LM with mask 0x25 → lmsm_reg 0, 2, 5; offsets 0, 1, 2; lmsm_last on the third cycle; busy for 2 cycles; p2_write_n = 0 on the third cycle.
- SM with mask 0x80 → single transfer of reg 7, lmsm_last = 1, no stall; mask 0x00 → no lmsm_valid.
- LM with mask 0xFF, ex_branch_taken on the 3rd transfer → flush all three registers, state RUN, the 4th transfer never issues.
- Reset pulse during LMSM → busy = 0 asynchronously. With PIPE_CTRL_PERF_EN: 70000 stall cycles → stall_cycles = 0xFFFF.
